// File: rtl/tcam_pkg.sv
// Shared definitions for the TCAM match encoder: default sizes, derived widths
// and the parameter legality rules used by every module of the block.
package tcam_pkg;

    localparam int DEF_DEPTH     = 64;
    localparam int DEF_SEG_WIDTH = 16;
    localparam int DEF_CNT_WIDTH = 32;

    // Index width for a vector of n entries; never below 1 so ports stay legal.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int calc_addr_width(input int depth);
        return idx_width(depth);
    endfunction

    function automatic int calc_nseg(input int depth, input int seg_width);
        return depth / seg_width;
    endfunction

    function automatic bit is_pow2(input int x);
        return (x > 0) && ((x & (x - 1)) == 0);
    endfunction

    // Segment width must tile the match vector exactly and be a power of two,
    // so that {segment, offset} concatenates into the flat entry index.
    function automatic bit params_legal(input int depth, input int seg_width);
        return (seg_width >= 2) && (seg_width <= depth) &&
               is_pow2(seg_width) && ((depth % seg_width) == 0);
    endfunction

endpackage

// File: rtl/tcam_prio_enc.sv
// Combinational priority encoder: lowest set bit index, any-set and
// two-or-more-set flags. idx is 0 when no bit is set.
module tcam_prio_enc
    import tcam_pkg::*;
#(
    parameter int WIDTH = DEF_SEG_WIDTH
) (
    input  logic [WIDTH-1:0]            vec,
    output logic [idx_width(WIDTH)-1:0] idx,
    output logic                        any,
    output logic                        multi
);

    localparam int IW = idx_width(WIDTH);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        idx = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = IW'(i);
            end
        end
    end

    // Clearing the lowest set bit leaves something only if two or more were set.
    always_comb begin
        any   = |vec;
        multi = |(vec & (vec - WIDTH'(1)));
    end

endmodule

// File: rtl/tcam_match_encoder.sv
// Two-stage pipelined priority encoder behind the TCAM match array.
// Stage 1 encodes each segment of the match vector; stage 2 picks the lowest
// hitting segment and forms the flat index. Saturating hit/miss counters are
// updated on each output transfer.
module tcam_match_encoder
    import tcam_pkg::*;
#(
    parameter int DEPTH     = DEF_DEPTH,
    parameter int SEG_WIDTH = DEF_SEG_WIDTH,
    parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [DEPTH-1:0]                    s_match,
    input  logic                                s_valid,
    output logic                                s_ready,
    output logic [calc_addr_width(DEPTH)-1:0]   m_index,
    output logic                                m_hit,
    output logic                                m_multi,
    output logic                                m_valid,
    input  logic                                m_ready,
    input  logic                                stat_clr,
    output logic [CNT_WIDTH-1:0]                hit_cnt,
    output logic [CNT_WIDTH-1:0]                miss_cnt
);

    localparam int ADDR_WIDTH = calc_addr_width(DEPTH);
    localparam int NSEG       = calc_nseg(DEPTH, SEG_WIDTH);
    localparam int SIW        = idx_width(SEG_WIDTH);
    localparam int KW         = idx_width(NSEG);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    if (!params_legal(DEPTH, SEG_WIDTH)) begin : g_bad_params
        $error("tcam_match_encoder: SEG_WIDTH must be a power of two dividing DEPTH");
    end

    logic                     st1_valid;
    logic                     st1_adv;
    logic                     st2_adv;
    logic                     out_xfer;

    logic [NSEG-1:0]          seg_hit_d;
    logic [NSEG-1:0]          seg_multi_d;
    logic [NSEG-1:0][SIW-1:0] seg_idx_d;

    logic [NSEG-1:0]          seg_hit_q;
    logic [NSEG-1:0]          seg_multi_q;
    logic [NSEG-1:0][SIW-1:0] seg_idx_q;

    logic [ADDR_WIDTH-1:0]    res_index;
    logic                     res_hit;
    logic                     res_multi;

    // Handshake: a stage may load when empty or when its content leaves now.
    always_comb begin
        st2_adv  = !m_valid || m_ready;
        st1_adv  = !st1_valid || st2_adv;
        s_ready  = st1_adv;
        out_xfer = m_valid && m_ready;
    end

    for (genvar k = 0; k < NSEG; k++) begin : g_seg
        tcam_prio_enc #(
            .WIDTH (SEG_WIDTH)
        ) u_seg_enc (
            .vec   (s_match[k*SEG_WIDTH +: SEG_WIDTH]),
            .idx   (seg_idx_d[k]),
            .any   (seg_hit_d[k]),
            .multi (seg_multi_d[k])
        );
    end

    // Stage 1 register: per-segment encodings of the accepted match vector.
    always_ff @(posedge clk) begin
        if (!rst) begin
            st1_valid   <= 1'b0;
            seg_hit_q   <= '0;
            seg_multi_q <= '0;
            seg_idx_q   <= '0;
        end else if (st1_adv) begin
            st1_valid <= s_valid;
            if (s_valid) begin
                seg_hit_q   <= seg_hit_d;
                seg_multi_q <= seg_multi_d;
                seg_idx_q   <= seg_idx_d;
            end
        end
    end

    if (NSEG > 1) begin : g_multi_seg
        logic [KW-1:0] sel_seg;
        logic          seg_over;

        tcam_prio_enc #(
            .WIDTH (NSEG)
        ) u_sel_enc (
            .vec   (seg_hit_q),
            .idx   (sel_seg),
            .any   (res_hit),
            .multi (seg_over)
        );

        // Any hit in a higher segment also makes the lookup a multi-match.
        always_comb begin
            res_index = '0;
            res_multi = 1'b0;
            if (res_hit) begin
                res_index = {sel_seg, seg_idx_q[sel_seg]};
                res_multi = seg_multi_q[sel_seg] || seg_over;
            end
        end
    end else begin : g_one_seg
        // A single segment already carries the full index.
        always_comb begin
            res_hit   = seg_hit_q[0];
            res_multi = seg_multi_q[0];
            res_index = ADDR_WIDTH'(seg_idx_q[0]);
        end
    end

    // Stage 2 register: the result presented downstream, held while stalled.
    always_ff @(posedge clk) begin
        if (!rst) begin
            m_valid <= 1'b0;
            m_index <= '0;
            m_hit   <= 1'b0;
            m_multi <= 1'b0;
        end else if (st2_adv) begin
            m_valid <= st1_valid;
            if (st1_valid) begin
                m_index <= res_index;
                m_hit   <= res_hit;
                m_multi <= res_multi;
            end
        end
    end

    // Saturating lookup statistics; a clear overrides a same-cycle increment.
    always_ff @(posedge clk) begin
        if (!rst || stat_clr) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (out_xfer) begin
            if (m_hit) begin
                if (hit_cnt != CNT_MAX) begin
                    hit_cnt <= hit_cnt + CNT_ONE;
                end
            end else begin
                if (miss_cnt != CNT_MAX) begin
                    miss_cnt <= miss_cnt + CNT_ONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_tcam_match_encoder.sv
// Scoreboard bench for tcam_match_encoder: accepted lookups are pushed with
// their reference result, and a negedge monitor pops and compares outputs.
module tb_tcam_match_encoder;

    typedef struct packed {
        logic [5:0] idx;
        logic       hit;
        logic       multi;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [63:0] s_match = '0;
    logic        s_valid = 1'b0;
    logic        m_ready = 1'b1;
    logic        stat_clr = 1'b0;

    logic        s_ready, m_hit, m_multi, m_valid;
    logic [5:0]  m_index;
    logic [31:0] hit_cnt, miss_cnt;

    logic        s_ready4, m_hit4, m_multi4, m_valid4;
    logic [5:0]  m_index4;
    logic [3:0]  hit_cnt4, miss_cnt4;

    int          n_checks = 0;
    int          n_fail = 0;
    bit          mon_en = 1'b0;

    exp_t        sb[$];
    longint unsigned exp_hit = 0, exp_miss = 0, exp_hit4 = 0, exp_miss4 = 0;
    bit          held = 1'b0;
    logic [5:0]  h_idx;
    logic        h_hit, h_multi;

    always #5 clk = ~clk;

    tcam_match_encoder #(.DEPTH(64), .SEG_WIDTH(16), .CNT_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .s_match(s_match), .s_valid(s_valid), .s_ready(s_ready),
        .m_index(m_index), .m_hit(m_hit), .m_multi(m_multi), .m_valid(m_valid),
        .m_ready(m_ready), .stat_clr(stat_clr), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    tcam_match_encoder #(.DEPTH(64), .SEG_WIDTH(16), .CNT_WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .s_match(s_match), .s_valid(s_valid), .s_ready(s_ready4),
        .m_index(m_index4), .m_hit(m_hit4), .m_multi(m_multi4), .m_valid(m_valid4),
        .m_ready(m_ready), .stat_clr(stat_clr), .hit_cnt(hit_cnt4), .miss_cnt(miss_cnt4)
    );

    task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    function automatic exp_t ref_model(input logic [63:0] v);
        exp_t r;
        r.idx   = '0;
        r.hit   = (v != 64'd0);
        r.multi = ($countones(v) >= 2);
        for (int i = 0; i < 64; i++) begin
            if (v[i]) begin
                r.idx = 6'(i);
                break;
            end
        end
        return r;
    endfunction

    function automatic longint unsigned sat_inc(input longint unsigned v, input longint unsigned mx);
        return (v >= mx) ? mx : v + 1;
    endfunction

    function automatic logic [63:0] rand_pat();
        logic [63:0] v;
        int s;
        case ($urandom_range(0, 4))
            0: v = '0;
            1: v = 64'd1 << $urandom_range(0, 63);
            2: v = (64'd1 << $urandom_range(0, 63)) | (64'd1 << $urandom_range(0, 63));
            3: begin
                s = $urandom_range(0, 3);
                v = {48'd0, 16'($urandom)} << (s * 16);
            end
            default: v = {$urandom, $urandom};
        endcase
        return v;
    endfunction

    // Monitor: checks handshake, stall stability and counters; pops on output
    // transfer and pushes on input transfer, both decided from settled signals.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("s_ready", s_ready, !(sb.size() == 2 && !m_ready));
            chk("s_ready_c4", s_ready4, !(sb.size() == 2 && !m_ready));
            if (sb.size() == 0) begin
                chk("m_valid_empty", m_valid, 0);
                chk("m_valid_empty_c4", m_valid4, 0);
            end
            if (held) begin
                chk("stall_valid", m_valid, 1);
                chk("stall_index", m_index, h_idx);
                chk("stall_hit", m_hit, h_hit);
                chk("stall_multi", m_multi, h_multi);
            end
            chk("hit_cnt", hit_cnt, exp_hit);
            chk("miss_cnt", miss_cnt, exp_miss);
            chk("hit_cnt_c4", hit_cnt4, exp_hit4);
            chk("miss_cnt_c4", miss_cnt4, exp_miss4);
            if (!rst) begin
                sb.delete();
                exp_hit = 0; exp_miss = 0; exp_hit4 = 0; exp_miss4 = 0;
                held = 1'b0;
            end else begin
                if (m_valid && m_ready) begin
                    if (sb.size() == 0) begin
                        fail_now("unexpected_output");
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        chk("m_index", m_index, e.idx);
                        chk("m_hit", m_hit, e.hit);
                        chk("m_multi", m_multi, e.multi);
                        chk("m_index_c4", m_index4, e.idx);
                        chk("m_multi_c4", m_multi4, e.multi);
                        if (!stat_clr) begin
                            if (e.hit) begin
                                exp_hit  = sat_inc(exp_hit, 64'hFFFF_FFFF);
                                exp_hit4 = sat_inc(exp_hit4, 15);
                            end else begin
                                exp_miss  = sat_inc(exp_miss, 64'hFFFF_FFFF);
                                exp_miss4 = sat_inc(exp_miss4, 15);
                            end
                        end
                    end
                end
                if (stat_clr) begin
                    exp_hit = 0; exp_miss = 0; exp_hit4 = 0; exp_miss4 = 0;
                end
                if (s_valid && s_ready) begin
                    sb.push_back(ref_model(s_match));
                end
                held    = m_valid && !m_ready;
                h_idx   = m_index;
                h_hit   = m_hit;
                h_multi = m_multi;
            end
        end
    end

    task automatic send(input logic [63:0] v);
        bit acc;
        int n;
        n = 0;
        s_match = v;
        s_valid = 1'b1;
        forever begin
            @(negedge clk);
            acc = s_ready;
            @(posedge clk);
            #1;
            if (acc) break;
            n++;
            if (n > 100) begin
                fail_now("send_timeout");
                break;
            end
        end
        s_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (sb.size() != 0) fail_now("drain_timeout");
        @(posedge clk);
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] pats [8];
        int sent;
        int c;
        bit full_seen;
        bit pend;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_index", m_index, 0);
        chk("rst_m_hit", m_hit, 0);
        chk("rst_m_multi", m_multi, 0);
        chk("rst_hit_cnt", hit_cnt, 0);
        chk("rst_miss_cnt", miss_cnt, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        mon_en = 1'b1;

        // First lookup: two-edge latency and counter visibility
        s_match = 64'h0000_0000_0001_0000;
        s_valid = 1'b1;
        @(negedge clk);
        chk("lat_accept", s_ready, 1);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        @(negedge clk);
        chk("lat_after_edge1", m_valid, 0);
        @(negedge clk);
        chk("lat_valid", m_valid, 1);
        chk("lat_index", m_index, 16);
        chk("lat_hit", m_hit, 1);
        chk("lat_multi", m_multi, 0);
        @(negedge clk);
        chk("first_hit_cnt", hit_cnt, 1);
        chk("first_miss_cnt", miss_cnt, 0);
        @(posedge clk);
        #1;

        // Directed patterns: cross-segment multi, in-segment multi, miss
        send(64'h8000_0000_0000_0100);
        send(64'h0000_0000_0000_0006);
        send(64'h0);
        drain();
        @(negedge clk);
        chk("dir_hit_cnt", hit_cnt, 3);
        chk("dir_miss_cnt", miss_cnt, 1);
        @(posedge clk);
        #1;

        // Back-to-back with m_ready low in cycles 3-6
        for (int i = 0; i < 8; i++) pats[i] = (64'd1 << (i * 8 + 3)) | (64'd1 << 63);
        sent = 0;
        full_seen = 1'b0;
        c = 0;
        while ((sent < 8 || sb.size() != 0) && c < 60) begin
            m_ready = !(c >= 3 && c <= 6);
            s_valid = (sent < 8);
            s_match = (sent < 8) ? pats[sent] : 64'd0;
            @(negedge clk);
            if (!s_ready) full_seen = 1'b1;
            if (s_valid && s_ready) sent++;
            @(posedge clk);
            #1;
            c++;
        end
        s_valid = 1'b0;
        m_ready = 1'b1;
        chk("stall_full_seen", full_seen, 1);
        chk("stall_all_sent", sent, 8);
        drain();

        // Randomized traffic with held inputs while not accepted
        pend = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (!pend) begin
                s_valid = ($urandom_range(0, 3) != 0);
                s_match = rand_pat();
            end
            m_ready  = ($urandom_range(0, 3) != 0);
            stat_clr = ($urandom_range(0, 49) == 0);
            @(negedge clk);
            pend = s_valid && !s_ready;
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
        stat_clr = 1'b0;
        m_ready = 1'b1;
        drain();

        // Reset with both stages full
        m_ready = 1'b0;
        send(64'h0000_0000_0000_0002);
        send(64'h8000_0000_0000_0000);
        @(negedge clk);
        chk("full_s_ready", s_ready, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("mrst_m_valid", m_valid, 0);
        chk("mrst_hit_cnt", hit_cnt, 0);
        chk("mrst_miss_cnt", miss_cnt, 0);
        chk("mrst_s_ready", s_ready, 1);
        @(posedge clk);
        #1;
        m_ready = 1'b1;
        send(64'h0000_0000_00F0_0000);
        drain();
        @(negedge clk);
        chk("post_rst_hit_cnt", hit_cnt, 1);
        @(posedge clk);
        #1;

        // Saturation of the 4-bit counters
        stat_clr = 1'b1;
        @(posedge clk);
        #1;
        stat_clr = 1'b0;
        @(negedge clk);
        chk("clr_hit_cnt", hit_cnt, 0);
        chk("clr_hit_cnt_c4", hit_cnt4, 0);
        @(posedge clk);
        #1;
        for (int i = 0; i < 20; i++) send(64'd1 << $urandom_range(0, 63));
        drain();
        @(negedge clk);
        chk("sat_hit_cnt_c4", hit_cnt4, 15);
        chk("sat_hit_cnt", hit_cnt, 20);
        @(posedge clk);
        #1;

        // stat_clr coinciding with an output transfer
        m_ready = 1'b0;
        send(64'd1 << 5);
        c = 0;
        while (!m_valid && c < 20) begin
            @(posedge clk);
            #1;
            c++;
        end
        if (!m_valid) fail_now("clr_xfer_wait_timeout");
        m_ready = 1'b1;
        stat_clr = 1'b1;
        @(posedge clk);
        #1;
        stat_clr = 1'b0;
        @(negedge clk);
        chk("clr_xfer_hit_cnt", hit_cnt, 0);
        chk("clr_xfer_hit_cnt_c4", hit_cnt4, 0);
        chk("clr_xfer_m_valid", m_valid, 0);
        @(posedge clk);
        #1;
        drain();

        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
